// File: rtl/lcd_sequencer.sv
// lcd_sequencer
//    HD44780-compatible write-only sequencer for an 8-bit LCD bus. After reset it
//    waits for the panel to power up, sends the fixed init sequence, then accepts
//    single command/data bytes over a ready/request handshake. Every lcd_en pulse
//    is framed by a one-cycle setup, a fixed high width and an execution hold.
//
// Ports
//    clk        : board clock (single domain)
//    rst        : asynchronous, active-high reset
//    wr_req     : write request, sampled on the rising edge of clk
//    wr_rs      : 0 = command, 1 = character data
//    wr_data    : byte to write
//    ready      : sequencer idle; a write presented now is accepted this edge
//    init_done  : power-on init finished (sticky until reset)
//    lcd_data   : LCD DB7..DB0
//    lcd_rs     : LCD register select
//    lcd_en     : LCD enable strobe
module lcd_sequencer #(
   parameter int PWR_CYC = 750000,
   parameter int EN_CYC  = 25,
   parameter int CMD_CYC = 2500,
   parameter int CLR_CYC = 82000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_req,
   input  logic       wr_rs,
   input  logic [7:0] wr_data,
   output logic       ready,
   output logic       init_done,
   output logic [7:0] lcd_data,
   output logic       lcd_rs,
   output logic       lcd_en
);

   localparam int MAX_CYC = (PWR_CYC > CLR_CYC) ? PWR_CYC : CLR_CYC;
   localparam int CW      = $clog2(MAX_CYC) + 1;

   // Counter reload values: a phase of N cycles loads N-1 and ends at zero.
   localparam logic [CW-1:0] PWR_LOAD = CW'(PWR_CYC - 1);
   localparam logic [CW-1:0] EN_LOAD  = CW'(EN_CYC - 1);
   localparam logic [CW-1:0] CMD_LOAD = CW'(CMD_CYC - 1);
   localparam logic [CW-1:0] CLR_LOAD = CW'(CLR_CYC - 1);

   localparam logic [2:0] ROM_LAST = 3'd5;

   typedef enum logic [2:0] {
      S_PWR_WAIT,
      S_SETUP,
      S_PULSE,
      S_HOLD,
      S_IDLE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    rom_idx_q, rom_idx_d;
   logic          ready_q, ready_d;
   logic          init_done_q, init_done_d;
   logic          lcd_en_q, lcd_en_d;
   logic [7:0]    lcd_data_q, lcd_data_d;
   logic          lcd_rs_q, lcd_rs_d;
   logic          is_clear;

   function automatic logic [7:0] rom_byte(input logic [2:0] idx);
      case (idx)
         3'd0, 3'd1, 3'd2: rom_byte = 8'h38;   // function set: 8-bit, 2 lines
         3'd3:             rom_byte = 8'h0C;   // display on, cursor off
         3'd4:             rom_byte = 8'h01;   // clear display
         3'd5:             rom_byte = 8'h06;   // entry mode: increment
         default:          rom_byte = 8'h00;
      endcase
   endfunction

   // Clear-display (0x01) and return-home (0x02/0x03) need the long execution time.
   assign is_clear = !lcd_rs_q && (lcd_data_q[7:2] == 6'd0) && (lcd_data_q[1:0] != 2'd0);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rom_idx_d   = rom_idx_q;
      lcd_data_d  = lcd_data_q;
      lcd_rs_d    = lcd_rs_q;

      case (state_q)
         S_PWR_WAIT: begin
            if (cnt_q == '0) begin
               state_d    = S_SETUP;
               rom_idx_d  = 3'd0;
               lcd_data_d = rom_byte(3'd0);
               lcd_rs_d   = 1'b0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_SETUP: begin
            state_d = S_PULSE;
            cnt_d   = EN_LOAD;
         end
         S_PULSE: begin
            if (cnt_q == '0) begin
               state_d = S_HOLD;
               cnt_d   = is_clear ? CLR_LOAD : CMD_LOAD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_HOLD: begin
            if (cnt_q == '0) begin
               // During init keep walking the ROM; otherwise return to idle.
               if (!init_done_q && (rom_idx_q != ROM_LAST)) begin
                  state_d    = S_SETUP;
                  rom_idx_d  = rom_idx_q + 3'd1;
                  lcd_data_d = rom_byte(rom_idx_q + 3'd1);
                  lcd_rs_d   = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_IDLE: begin
            if (wr_req) begin
               state_d    = S_SETUP;
               lcd_data_d = wr_data;
               lcd_rs_d   = wr_rs;
            end
         end
         default: begin
            state_d = S_PWR_WAIT;
            cnt_d   = PWR_LOAD;
         end
      endcase

      // Outputs are decoded from the next state so each register lines up with its state.
      ready_d     = (state_d == S_IDLE);
      lcd_en_d    = (state_d == S_PULSE);
      init_done_d = init_done_q | (state_d == S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_PWR_WAIT;
         cnt_q       <= PWR_LOAD;
         rom_idx_q   <= 3'd0;
         ready_q     <= 1'b0;
         init_done_q <= 1'b0;
         lcd_en_q    <= 1'b0;
         lcd_data_q  <= 8'h00;
         lcd_rs_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rom_idx_q   <= rom_idx_d;
         ready_q     <= ready_d;
         init_done_q <= init_done_d;
         lcd_en_q    <= lcd_en_d;
         lcd_data_q  <= lcd_data_d;
         lcd_rs_q    <= lcd_rs_d;
      end
   end

   assign ready     = ready_q;
   assign init_done = init_done_q;
   assign lcd_en    = lcd_en_q;
   assign lcd_data  = lcd_data_q;
   assign lcd_rs    = lcd_rs_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// tb_lcd_sequencer
//    Scoreboard bench for lcd_sequencer with small timing parameters. Every byte
//    expected on the LCD bus is queued when it is requested (or when an init is
//    started) and popped when the monitor sees the matching lcd_en rising edge.
module tb_lcd_sequencer;

   localparam int PWR = 10;
   localparam int EN  = 2;
   localparam int CMD = 4;
   localparam int CLR = 8;
   localparam int INIT_LAT = PWR + 5 * (1 + EN + CMD) + (1 + EN + CLR);   // 56

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_req = 1'b0;
   logic       wr_rs = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       ready;
   logic       init_done;
   logic [7:0] lcd_data;
   logic       lcd_rs;
   logic       lcd_en;

   always #5 clk = ~clk;

   lcd_sequencer #(
      .PWR_CYC (PWR),
      .EN_CYC  (EN),
      .CMD_CYC (CMD),
      .CLR_CYC (CLR)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_req    (wr_req),
      .wr_rs     (wr_rs),
      .wr_data   (wr_data),
      .ready     (ready),
      .init_done (init_done),
      .lcd_data  (lcd_data),
      .lcd_rs    (lcd_rs),
      .lcd_en    (lcd_en)
   );

   typedef struct packed {
      logic       rs;
      logic [7:0] data;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] rom_exp [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int last_rise = 0;
   int prev_rise = 0;

   task automatic chk(input string tag, input int obs, input int exp_v);
      checks++;
      if (obs != exp_v) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp_v, exp_v);
      end
   endtask

   task automatic push_rom();
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back({1'b0, rom_exp[i]});
      end
   endtask

   // Count negedge samples from the current point until init_done rises.
   task automatic wait_init(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!init_done && n < 500);
   endtask

   // Count consecutive busy samples, starting with the current one.
   task automatic busy_count(output int n);
      n = 0;
      while (!ready && n < 1000) begin
         n++;
         @(negedge clk);
      end
   endtask

   // Must be called at a negedge with ready=1.
   task automatic do_write(input logic rs, input logic [7:0] data, input int exp_low, input string tag);
      int n;
      chk({tag, "_ready_before"}, int'(ready), 1);
      wr_rs   = rs;
      wr_data = data;
      wr_req  = 1'b1;
      exp_q.push_back({rs, data});
      @(negedge clk);
      wr_req = 1'b0;
      busy_count(n);
      chk({tag, "_busy"}, n, exp_low);
      $display("write rs=%0d data=0x%02h busy=%0d cycles", rs, data, n);
   endtask

   // Bus monitor: pops the scoreboard on each lcd_en rise and checks width/stability.
   initial begin
      exp_t       cur;
      logic       en_prev = 1'b0;
      logic       in_pulse = 1'b0;
      logic [7:0] prev_data = 8'h00;
      logic       prev_rs = 1'b0;
      int         width = 0;
      cur = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            en_prev  = 1'b0;
            in_pulse = 1'b0;
         end else begin
            if (lcd_en && !en_prev) begin
               prev_rise = last_rise;
               last_rise = cyc;
               $display("pulse rs=%0d data=0x%02h at cycle %0d", lcd_rs, lcd_data, cyc);
               if (exp_q.size() == 0) begin
                  chk("unexpected_pulse", 1, 0);
                  in_pulse = 1'b0;
               end else begin
                  cur = exp_q.pop_front();
                  chk("pulse_data", int'({lcd_rs, lcd_data}), int'(cur));
                  chk("setup_data", int'({prev_rs, prev_data}), int'(cur));
                  in_pulse = 1'b1;
                  width    = 1;
               end
            end else if (lcd_en) begin
               width++;
            end else if (en_prev && in_pulse) begin
               chk("pulse_width", width, EN);
               chk("hold_data", int'({lcd_rs, lcd_data}), int'(cur));
               in_pulse = 1'b0;
            end
            en_prev = lcd_en;
         end
         prev_data = lcd_data;
         prev_rs   = lcd_rs;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int bad;
      int r;

      // Reset and power-on init.
      repeat (3) @(negedge clk);
      chk("rst_outputs", int'({ready, init_done, lcd_en, lcd_rs, lcd_data}), 0);
      push_rom();
      rst = 1'b0;
      wait_init(n);
      chk("init_latency", n, INIT_LAT);
      chk("init_ready", int'(ready), 1);
      chk("init_drained", exp_q.size(), 0);
      $display("init done after %0d cycles", n);

      // Single writes and the clear-command hold rule.
      do_write(1'b1, 8'h41, 1 + EN + CMD, "wr_data41");
      do_write(1'b0, 8'h01, 1 + EN + CLR, "wr_clear");
      do_write(1'b1, 8'h01, 1 + EN + CMD, "wr_data01");
      do_write(1'b0, 8'h02, 1 + EN + CLR, "wr_home");
      do_write(1'b0, 8'h80, 1 + EN + CMD, "wr_ddram");

      // Back-to-back with wr_req held high.
      wr_rs   = 1'b1;
      wr_data = 8'h55;
      wr_req  = 1'b1;
      exp_q.push_back({1'b1, 8'h55});
      @(negedge clk);
      wr_data = 8'hAA;
      exp_q.push_back({1'b1, 8'hAA});
      bad = 0;
      n   = 0;
      while (!ready && n < 1000) begin
         if (lcd_data != 8'h55) bad++;
         n++;
         @(negedge clk);
      end
      chk("b2b_first_busy", n, 1 + EN + CMD);
      chk("b2b_first_stable", bad, 0);
      @(negedge clk);
      wr_req = 1'b0;
      chk("b2b_second_accept", int'(ready), 0);
      // Request while busy must be ignored.
      @(negedge clk);
      wr_data = 8'h77;
      wr_req  = 1'b1;
      @(negedge clk);
      wr_req = 1'b0;
      busy_count(n);
      chk("b2b_second_done", int'(ready), 1);
      chk("b2b_spacing", last_rise - prev_rise, 2 + EN + CMD);
      $display("write back-to-back 0x55/0xAA rise spacing=%0d", last_rise - prev_rise);
      r = last_rise;
      repeat (12) @(negedge clk);
      chk("ignored_req_no_pulse", last_rise, r);
      chk("ignored_req_ready", int'(ready), 1);

      // Reset during the second cycle of a user pulse.
      wr_rs   = 1'b1;
      wr_data = 8'h33;
      wr_req  = 1'b1;
      exp_q.push_back({1'b1, 8'h33});
      @(negedge clk);
      wr_req = 1'b0;
      n = 0;
      while (!lcd_en && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("rstp_pulse_seen", int'(lcd_en), 1);
      @(negedge clk);
      chk("rstp_en_before", int'(lcd_en), 1);
      rst = 1'b1;
      #1;
      chk("rstp_en_async", int'(lcd_en), 0);
      chk("rstp_init_done", int'(init_done), 0);
      chk("rstp_ready", int'(ready), 0);
      $display("reset asserted mid-pulse");
      repeat (2) @(negedge clk);
      push_rom();
      rst = 1'b0;
      wait_init(n);
      chk("reinit_latency", n, INIT_LAT);
      chk("reinit_drained", exp_q.size(), 0);
      $display("re-init done after %0d cycles", n);

      // wr_req held from reset release: first user write rides right behind init.
      @(negedge clk);
      rst     = 1'b1;
      wr_req  = 1'b1;
      wr_rs   = 1'b1;
      wr_data = 8'h5A;
      repeat (2) @(negedge clk);
      push_rom();
      exp_q.push_back({1'b1, 8'h5A});
      rst = 1'b0;
      wait_init(n);
      chk("reqhi_latency", n, INIT_LAT);
      chk("reqhi_ready", int'(ready), 1);
      @(negedge clk);
      chk("reqhi_accepted", int'(ready), 0);
      wr_req = 1'b0;
      busy_count(n);
      chk("reqhi_busy", n, 1 + EN + CMD);
      $display("write rs=1 data=0x5a held from reset, busy=%0d cycles", n);

      repeat (5) @(negedge clk);
      chk("final_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lcd_sequencer.md
# lcd_sequencer

HD44780-compatible LCD sequencer for an 8-bit, write-only bus (RW tied low on the board). It runs on the 50 MHz board clock and performs the power-on initialisation sequence. It then accepts single-byte command/data writes from the training core over a ready/request handshake. It generates every `lcd_en` pulse with guaranteed setup, pulse-width and execution-time spacing, and drives the `lcd_data`/`lcd_rs`/`lcd_en` header pins directly.

## Interface
- `PWR_CYC`, 750000: power-on wait after reset release (15 ms at 50 MHz).
- `EN_CYC`, 25: `lcd_en` high width in cycles (500 ns).
- `CMD_CYC`, 2500: post-pulse hold for ordinary commands/data (50 µs).
- `CLR_CYC`, 82000: post-pulse hold for clear-display/return-home (1.64 ms).
- `clk` in 1: board clock; one clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `wr_req` in 1: write request, sampled on `clk` rising edge.
- `wr_rs` in 1: 0 = command, 1 = character data.
- `wr_data` in 8: byte to write.
- `ready` out 1: sequencer idle, a write will be accepted this cycle.
- `init_done` out 1: power-on init complete; sticky until reset.
- `lcd_data` out 8: LCD DB7..DB0.
- `lcd_rs` out 1: LCD register select.
- `lcd_en` out 1: LCD enable strobe.

## Operation
- All outputs are registered. Reset value of every output is 0. `rst` forces `lcd_en` low immediately (asynchronously) and restarts the full init sequence.
- States:
  - PWR_WAIT: counts `PWR_CYC` cycles, `lcd_en` low.
  - SETUP: 1 cycle; drives `lcd_data`/`lcd_rs`, `lcd_en` low.
  - PULSE: `EN_CYC` cycles, `lcd_en` high.
  - HOLD: `lcd_en` low, counts the hold time.
  - IDLE.
- Init ROM is sent in order with rs=0: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06. Each byte passes SETUP→PULSE→HOLD; the ROM index advances after HOLD.
- Hold length is `CLR_CYC` when rs=0 and byte ∈ {0x01, 0x02, 0x03}; otherwise it is `CMD_CYC`. The same rule applies to user writes.
- After the last ROM byte's HOLD, the block enters IDLE. `init_done` and `ready` both rise in that cycle.
- IDLE: `ready`=1. On an edge where `wr_req`=1, `wr_rs`/`wr_data` are captured into internal registers and the state moves to SETUP; `ready`=0 from the next cycle.
- `wr_req` while `ready`=0 is ignored. There is no queue and no error flag; the requester must hold `wr_req` until it sees acceptance.
- `lcd_data`/`lcd_rs` change only on entry to SETUP. They stay stable through PULSE and HOLD and keep their last value in IDLE.
- The counter is one shared down-counter sized to `$clog2(max(PWR_CYC,CLR_CYC))+1` bits. A parameter value of 0 is illegal. Minimum values are `EN_CYC`≥1 and `CMD_CYC`≥1.

## Timing
- Acceptance edge k (`ready`=1, `wr_req`=1):
  - Cycle k+1 is SETUP.
  - Cycles k+2 … k+1+`EN_CYC` have `lcd_en`=1.
  - HOLD lasts H cycles.
  - `ready`=1 again in cycle k+2+`EN_CYC`+H.
  - `ready` is low for exactly 1+`EN_CYC`+H cycles per write.
- Back-to-back: if `wr_req` is held high, the next write is accepted on the first `ready`=1 edge. Spacing between `lcd_en` rising edges is therefore 2+`EN_CYC`+H cycles.
- Init latency from the `rst` falling edge to `init_done`: `PWR_CYC` + 5·(1+`EN_CYC`+`CMD_CYC`) + (1+`EN_CYC`+`CLR_CYC`) cycles.
- `rst` asserted mid-PULSE truncates the pulse. On release, init restarts from PWR_WAIT; the in-flight write is lost.
- `wr_req` asserted during init: ignored, because `ready`=0.

## Test plan
Use `PWR_CYC`=10, `EN_CYC`=2, `CMD_CYC`=4, `CLR_CYC`=8.
- Reset then release: all outputs 0 during reset. Six `lcd_en` pulses carry data 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 with rs=0, each 2 cycles wide. `init_done`=`ready`=1 exactly 56 cycles after release.
- After init, single write rs=1 data 0x41: `lcd_data`=0x41 one cycle before `lcd_en` rises. `lcd_en` is high 2 cycles. `ready` is low exactly 7 cycles.
- Command 0x01 with rs=0 after init: `ready` is low exactly 11 cycles. The same byte with rs=1 gives 7 cycles.
- `wr_req` held high with two different bytes presented back-to-back: the `lcd_en` rising edges are 8 cycles apart. The second byte is not driven before the first HOLD ends. `wr_req` pulsed while `ready`=0 produces no pulse.
- `rst` asserted during the second cycle of a user PULSE: `lcd_en`=0 in the same cycle and `init_done`=0. After release, the full 56-cycle init repeats.
- `wr_req`=1 continuously from reset release: the first user write is accepted in cycle 56 (with `init_done`). No user byte appears before the ROM's 0x06.
